// File: rtl/echo_detector.sv
`timescale 1ns/1ps
// echo_detector
// Rectifies beamformed samples about midscale, smooths them with a moving
// average and qualifies echoes with blanking, hysteresis and a confirm count.
// Optional feature macro: ECHO_PEAK_TRACK_EN (peak envelope tracking on peak_out).
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset; waits for the first burst, never detects
// BLANK    | ignoring transmitter ringing for BLANK_SAMPLES samples
// ARMED    | waiting for envelope >= THRESHOLD
// CONFIRM  | candidate latched; counting envelopes above the low level
// DETECTED | echo reported; holds until the next burst
module echo_detector #(
    parameter int DATA_WIDTH    = 16,
    parameter int MIDSCALE      = 32768,
    parameter int WINDOW_LOG2   = 3,
    parameter int THRESHOLD     = 5000,
    parameter int HYSTERESIS    = 1000,
    parameter int CONFIRM_COUNT = 3,
    parameter int BLANK_SAMPLES = 200,
    parameter int TIME_WIDTH    = 24
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  burst_start_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    input  logic [TIME_WIDTH-1:0] time_in,
    output logic [DATA_WIDTH-1:0] envelope_out,
    output logic                  envelope_valid_out,
    output logic                  echo_detected_out,
    output logic                  echo_pulse_out,
    output logic [TIME_WIDTH-1:0] echo_time_out,
    output logic [DATA_WIDTH-1:0] peak_out
);

    localparam int WIN   = 1 << WINDOW_LOG2;
    localparam int SUM_W = DATA_WIDTH + WINDOW_LOG2;
    localparam int CNT_W = $clog2(CONFIRM_COUNT + 1);
    localparam int BLK_W = (BLANK_SAMPLES > 0) ? $clog2(BLANK_SAMPLES + 1) : 1;
    localparam int LOW_I = (THRESHOLD > HYSTERESIS) ? (THRESHOLD - HYSTERESIS) : 0;

    localparam logic [DATA_WIDTH:0]   MID_X    = (DATA_WIDTH + 1)'(MIDSCALE);
    localparam logic [DATA_WIDTH-1:0] THR_HI   = DATA_WIDTH'(THRESHOLD);
    localparam logic [DATA_WIDTH-1:0] THR_LO   = DATA_WIDTH'(LOW_I);
    localparam logic [CNT_W-1:0]      CONF_C   = CNT_W'(CONFIRM_COUNT);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [BLK_W-1:0]      BLK_LOAD = BLK_W'(BLANK_SAMPLES);
    localparam logic [BLK_W-1:0]      BLK_ONE  = BLK_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_ARMED,
        S_CONFIRM,
        S_DETECTED
    } state_t;

    // Stage 1: rectification. diff holds a two's-complement bit pattern.
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH:0]   neg_diff;
    logic [DATA_WIDTH:0]   mag;
    logic [DATA_WIDTH-1:0] rect;
    logic [DATA_WIDTH-1:0] rect_q;
    logic [TIME_WIDTH-1:0] time_q;
    logic                  rect_valid_q;

    assign diff     = {1'b0, sample_in} - MID_X;
    assign neg_diff = MID_X - {1'b0, sample_in};

    // absolute value with saturation to the sample width
    always_comb begin
        mag  = diff[DATA_WIDTH] ? neg_diff : diff;
        rect = mag[DATA_WIDTH] ? '1 : mag[DATA_WIDTH-1:0];
    end

    // stage-1 register; a burst drops whatever sample arrives with it
    always_ff @(posedge clk_in) begin
        if (rst_in || burst_start_in) begin
            rect_valid_q <= 1'b0;
            rect_q       <= '0;
            time_q       <= '0;
        end else begin
            rect_valid_q <= sample_valid_in;
            if (sample_valid_in) begin
                rect_q <= rect;
                time_q <= time_in;
            end
        end
    end

    // Stage 2: moving average over WIN samples, running sum
    logic [DATA_WIDTH-1:0] window [WIN];
    logic [SUM_W-1:0]      sum_q;
    logic [SUM_W-1:0]      sum_next;
    logic [TIME_WIDTH-1:0] env_time_q;

    assign sum_next = sum_q + SUM_W'(rect_q) - SUM_W'(window[WIN-1]);

    // window shift, running sum and registered envelope
    always_ff @(posedge clk_in) begin
        if (rst_in || burst_start_in) begin
            for (int i = 0; i < WIN; i++) window[i] <= '0;
            sum_q              <= '0;
            envelope_out       <= '0;
            envelope_valid_out <= 1'b0;
            env_time_q         <= '0;
        end else begin
            envelope_valid_out <= rect_valid_q;
            if (rect_valid_q) begin
                window[0] <= rect_q;
                for (int i = 1; i < WIN; i++) window[i] <= window[i-1];
                sum_q        <= sum_next;
                envelope_out <= sum_next[SUM_W-1:WINDOW_LOG2];
                env_time_q   <= time_q;
            end
        end
    end

    // Detection FSM
    state_t                state_q, state_d;
    logic [BLK_W-1:0]      blank_q, blank_d;
    logic [CNT_W-1:0]      count_q, count_d, count_inc;
    logic [TIME_WIDTH-1:0] cand_q, cand_d;
    logic                  fire;

    assign count_inc = count_q + 1'b1;

    // state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            blank_q <= '0;
            count_q <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            count_q <= count_d;
            cand_q  <= cand_d;
        end
    end

    // next state; burst overrides everything, otherwise act only on valid envelopes
    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        count_d = count_q;
        cand_d  = cand_q;
        fire    = 1'b0;
        if (burst_start_in) begin
            state_d = (BLANK_SAMPLES == 0) ? S_ARMED : S_BLANK;
            blank_d = BLK_LOAD;
            count_d = '0;
            cand_d  = '0;
        end else if (envelope_valid_out) begin
            case (state_q)
                S_BLANK: begin
                    blank_d = blank_q - 1'b1;
                    if (blank_q <= BLK_ONE) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (envelope_out >= THR_HI) begin
                        cand_d  = env_time_q;
                        count_d = CNT_ONE;
                        if (CNT_ONE >= CONF_C) begin
                            state_d = S_DETECTED;
                            fire    = 1'b1;
                        end else begin
                            state_d = S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (envelope_out >= THR_LO) begin
                        count_d = count_inc;
                        if (count_inc >= CONF_C) begin
                            state_d = S_DETECTED;
                            fire    = 1'b1;
                        end
                    end else begin
                        state_d = S_ARMED;
                        count_d = '0;
                        cand_d  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // detection outputs, registered one cycle after the confirming envelope
    always_ff @(posedge clk_in) begin
        if (rst_in || burst_start_in) begin
            echo_detected_out <= 1'b0;
            echo_pulse_out    <= 1'b0;
            echo_time_out     <= '0;
        end else begin
            echo_pulse_out <= fire;
            if (fire) begin
                echo_detected_out <= 1'b1;
                echo_time_out     <= cand_d;
            end
        end
    end

`ifdef ECHO_PEAK_TRACK_EN
    logic [DATA_WIDTH-1:0] peak_q;

    // running maximum of envelopes seen once blanking has ended
    always_ff @(posedge clk_in) begin
        if (rst_in || burst_start_in) begin
            peak_q <= '0;
        end else if (envelope_valid_out &&
                     ((state_q == S_ARMED) || (state_q == S_CONFIRM) || (state_q == S_DETECTED)) &&
                     (envelope_out > peak_q)) begin
            peak_q <= envelope_out;
        end
    end

    assign peak_out = peak_q;
`else
    assign peak_out = '0;
`endif

endmodule
